// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and types for the sync_fifo read-side adapter
package fifo_pkg;

  localparam int FIFO_RD_LATENCY = 1;
  localparam int RD_BUF_DEPTH    = 3;

  typedef logic [1:0] rd_ptr_t;
  typedef logic [1:0] rd_cnt_t;

  function automatic rd_ptr_t ptr_inc(input rd_ptr_t p);
    return (p == rd_ptr_t'(RD_BUF_DEPTH - 1)) ? rd_ptr_t'(0) : rd_ptr_t'(p + 2'd1);
  endfunction

endpackage

// File: rtl/sync_fifo_reader.sv
// rtl/sync_fifo_reader.sv - drains a registered-read sync_fifo into a valid/ready stream
module sync_fifo_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             fifo_pop_o,
  input  logic             fifo_empty_i,
  input  logic [WIDTH-1:0] fifo_data_i,
  input  logic             flush_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);

  rd_cnt_t          count_q, count_d;
  logic             inflight_q, inflight_d;
  logic             drop_q, drop_d;
  rd_ptr_t          rd_ptr_q, rd_ptr_d;
  rd_ptr_t          wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] mem_q [RD_BUF_DEPTH];
  logic [WIDTH-1:0] mem_d [RD_BUF_DEPTH];

  logic credit_ok;
  logic capture;
  logic handshake;

  // Credit counts words in flight too, so ready_i never reaches the pop path.
  assign credit_ok  = ({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3;
  assign fifo_pop_o = rst_ni && !flush_i && !fifo_empty_i && credit_ok;
  assign valid_o    = (count_q != rd_cnt_t'(0));
  assign data_o     = mem_q[rd_ptr_q];
  assign handshake  = valid_o && ready_i;
  // A word landing during a flush is squashed here rather than through drop_q.
  assign capture    = inflight_q && !drop_q && !flush_i;

  always_comb begin
    count_d    = count_q;
    inflight_d = fifo_pop_o;
    drop_d     = drop_q && !inflight_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mem_d      = mem_q;

    if (capture) begin
      mem_d[wr_ptr_q] = fifo_data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end

    if (handshake) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    case ({capture, handshake})
      2'b10:   count_d = count_q + rd_cnt_t'(1);
      2'b01:   count_d = count_q - rd_cnt_t'(1);
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      drop_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_reader.sv
// tb/tb_sync_fifo_reader.sv - scoreboard bench for sync_fifo_reader
module tb_sync_fifo_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_pop;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        flush;
  logic        valid;
  logic        ready;
  logic [31:0] data;

  int checks   = 0;
  int failures = 0;

  logic [31:0] fmem [0:1023];
  int          fwr = 0;
  int          frd = 0;
  int          outst = 0;
  logic [31:0] exp_q [$];
  bit          push_done;

  always #5 clk = ~clk;

  sync_fifo_reader #(.WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .fifo_pop_o  (fifo_pop),
    .fifo_empty_i(fifo_empty),
    .fifo_data_i (fifo_data),
    .flush_i     (flush),
    .valid_o     (valid),
    .ready_i     (ready),
    .data_o      (data)
  );

  // Upstream FIFO model: registered read data, one cycle after pop.
  assign fifo_empty = (fwr == frd);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frd       <= fwr;
      fifo_data <= '0;
    end else if (fifo_pop) begin
      fifo_data <= fmem[frd];
      frd       <= frd + 1;
    end
  end

  // Independent credit tracker: words popped but not yet consumed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      outst <= 0;
    else if (flush)  outst <= 0;
    else             outst <= outst + int'(fifo_pop) - int'(valid && ready);
  end

  always @(negedge clk) begin
    if (rst_n && fifo_pop) begin
      checks++;
      if (outst >= 3) begin
        failures++;
        $display("FAIL credit_pop actual_outstanding=%0d required_below=3", outst);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual=%h required=none", data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (data !== e) begin
          failures++;
          $display("FAIL sb_data actual=%h required=%h", data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fpush(input logic [31:0] d, input bit expect_out);
    fmem[fwr] = d;
    fwr++;
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ready = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_pop", 32'(fifo_pop), 32'd0);
    tick();
    rst_n = 1'b1;

    // Empty FIFO: nothing pops, nothing appears.
    ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("empty_pop", 32'(fifo_pop), 32'd0);
      chk("empty_valid", 32'(valid), 32'd0);
    end

    // Streaming: pops in cycles 0..2, valid in cycles 2..4.
    tick();
    fpush(32'h11, 1'b1);
    fpush(32'h22, 1'b1);
    fpush(32'h33, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("stream_pop_c%0d", k), 32'(fifo_pop), 32'(k <= 2));
      chk($sformatf("stream_valid_c%0d", k), 32'(valid), 32'(k >= 2 && k <= 4));
    end
    wait_drain(20);

    // Backpressure: exactly three pops, head word held.
    tick();
    ready = 1'b0;
    for (int i = 0; i < 8; i++) fpush(32'hA0 + 32'(i), 1'b1);
    begin
      int npops = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        npops += int'(fifo_pop);
      end
      chk("bp_pops", 32'(npops), 32'd3);
    end
    chk("bp_valid", 32'(valid), 32'd1);
    chk("bp_data", data, 32'hA0);
    tick();
    ready = 1'b1;
    wait_drain(100);

    // Random ready with random push gaps.
    push_done = 1'b0;
    fork
      begin
        int i = 0;
        while (i < 256) begin
          tick();
          if ($urandom_range(0, 3) != 0) begin
            fpush(32'h1000 + 32'(i), 1'b1);
            i++;
          end
        end
        push_done = 1'b1;
      end
      begin
        while (!push_done) begin
          tick();
          ready = 1'($urandom_range(0, 1));
        end
      end
    join
    tick();
    ready = 1'b1;
    wait_drain(2000);

    // Flush while 0x44 buffered and 0x55 in flight; 0x66 waits in the FIFO.
    tick();
    ready = 1'b0;
    fpush(32'h44, 1'b0);
    tick();
    fpush(32'h55, 1'b0);
    tick();
    flush = 1'b1;
    fpush(32'h66, 1'b1);
    @(negedge clk);
    chk("flush_pre_valid", 32'(valid), 32'd1);
    chk("flush_pre_data", data, 32'h44);
    chk("flush_no_pop", 32'(fifo_pop), 32'd0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_post_valid", 32'(valid), 32'd0);
    tick();
    ready = 1'b1;
    wait_drain(20);

    // Asynchronous reset in the middle of a stream.
    tick();
    for (int i = 0; i < 8; i++) fpush(32'hB0 + 32'(i), 1'b1);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_data", data, 32'd0);
    chk("arst_pop", 32'(fifo_pop), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    fpush(32'h77, 1'b1);
    fpush(32'h88, 1'b1);
    wait_drain(20);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
